// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage operand forwarding logic:
// default widths, the forwarding-source encoding and the history entry layout.
package riscv_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int REG_AW_DEFAULT = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_H0   = 2'd1,
      FWD_H1   = 2'd2,
      FWD_IMM  = 2'd3
   } fwd_src_e;

   typedef struct packed {
      logic                      valid;
      logic [REG_AW_DEFAULT-1:0] rd;
      logic [XLEN_DEFAULT-1:0]   data;
   } hist_entry_t;

endpackage

// File: rtl/fwd_hist_entry.sv
// One slot of the retired-result history. load_i captures a full entry,
// clear_i drops only the valid bit (rd/data are don't-care once invalid),
// otherwise the slot holds. Reset wipes every field.
module fwd_hist_entry
   import riscv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic              valid_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [XLEN-1:0]   data_i,
   output logic              valid_o,
   output logic [REG_AW-1:0] rd_o,
   output logic [XLEN-1:0]   data_o
);

   logic              valid_q, valid_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [XLEN-1:0]   data_q, data_d;

   // Next-state selection: clear wins over load so a flush can never be undone.
   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = valid_i;
         rd_d    = rd_i;
         data_d  = data_i;
      end
   end

   // Slot storage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign rd_o    = rd_q;
   assign data_o  = data_q;

endmodule

// File: rtl/operand_b_forward.sv
// ALU operand-B selector with a two-deep forwarding history of retired
// results. Selection is purely combinational; only the history and the
// saturating forward counter are registered.
module operand_b_forward
   import riscv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [XLEN-1:0]   imm,
   input  logic              alu_b_src,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              stall,
   input  logic              flush,
   output logic [XLEN-1:0]   operand_b,
   output logic [1:0]        fwd_src,
   output logic [15:0]       fwd_count
);

   logic              h0Valid, h1Valid;
   logic [REG_AW-1:0] h0Rd, h1Rd;
   logic [XLEN-1:0]   h0Data, h1Data;
   logic              advance;
   logic              h0Match, h1Match;
   fwd_src_e          fwdSel;
   logic [15:0]       fwd_count_q, fwd_count_d;

   // The history shifts only on an unstalled, unflushed edge.
   assign advance = !stall && !flush;

   // Newest slot: takes the retiring result, or goes invalid on an idle cycle.
   fwd_hist_entry #(.XLEN(XLEN), .REG_AW(REG_AW)) u_h0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (advance && wb_valid),
      .clear_i (flush || (advance && !wb_valid)),
      .valid_i (1'b1),
      .rd_i    (wb_rd),
      .data_i  (wb_data),
      .valid_o (h0Valid),
      .rd_o    (h0Rd),
      .data_o  (h0Data)
   );

   // Older slot: inherits whatever the newest slot held, valid bit included.
   fwd_hist_entry #(.XLEN(XLEN), .REG_AW(REG_AW)) u_h1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (advance),
      .clear_i (flush),
      .valid_i (h0Valid),
      .rd_i    (h0Rd),
      .data_i  (h0Data),
      .valid_o (h1Valid),
      .rd_o    (h1Rd),
      .data_o  (h1Data)
   );

   // x0 is hardwired to zero, so a write to it must never be forwarded.
   assign h0Match = h0Valid && (h0Rd == rs2_addr) && (h0Rd != '0);
   assign h1Match = h1Valid && (h1Rd == rs2_addr) && (h1Rd != '0);

   // Priority mux: immediate, then newest history, then older, then regfile.
   always_comb begin
      fwdSel    = FWD_NONE;
      operand_b = rs2_data;
      if (alu_b_src) begin
         fwdSel    = FWD_IMM;
         operand_b = imm;
      end else if (h0Match) begin
         fwdSel    = FWD_H0;
         operand_b = h0Data;
      end else if (h1Match) begin
         fwdSel    = FWD_H1;
         operand_b = h1Data;
      end
   end

   assign fwd_src = fwdSel;

   // Counter advances on forwarded operands only, sticking at all-ones.
   always_comb begin
      fwd_count_d = fwd_count_q;
      if (advance && (fwdSel == FWD_H0 || fwdSel == FWD_H1) && (fwd_count_q != 16'hFFFF)) begin
         fwd_count_d = fwd_count_q + 16'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_count_q <= 16'd0;
      end else begin
         fwd_count_q <= fwd_count_d;
      end
   end

   assign fwd_count = fwd_count_q;

endmodule

// File: doc/operand_b_forward.md
OPERAND_B_FORWARD -- requirements
Module: operand_b_forward

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL expose parameter XLEN, default 32, meaning operand and result data width.
REQ-003 The block SHALL expose parameter REG_AW, default 5, meaning register address width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 rs2_addr  input  REG_AW  source register 2 index of the instruction in execute.
REQ-007 rs2_data  input  XLEN  register-file read data for rs2_addr.
REQ-008 imm  input  XLEN  decoded immediate.
REQ-009 alu_b_src  input  1  1 = immediate, 0 = register path.
REQ-010 wb_valid  input  1  a result is retiring this cycle.
REQ-011 wb_rd  input  REG_AW  destination index of the retiring result.
REQ-012 wb_data  input  XLEN  retiring result value.
REQ-013 stall  input  1  pipeline frozen this cycle.
REQ-014 flush  input  1  discard all in-flight results.
REQ-015 operand_b  output  XLEN  selected ALU operand B.
REQ-016 fwd_src  output  2  forwarding source encoding, fwd_src_e.
REQ-017 fwd_count  output  16  saturating count of forwarded operands.

Function
REQ-018 The block SHALL hold a two-entry result history, H0 (newest) and H1 (older); each entry stores valid, rd and data.
REQ-019 On a clock edge with wb_valid=1, stall=0 and flush=0, H1 SHALL take H0, and H0 SHALL take {1, wb_rd, wb_data}.
REQ-020 On a clock edge with wb_valid=0, stall=0 and flush=0, H1 SHALL take H0, and H0.valid SHALL clear.
REQ-021 On a clock edge with stall=1 and flush=0, the history and fwd_count SHALL hold; wb_valid SHALL be ignored.
REQ-022 On a clock edge with flush=1, both valid bits SHALL clear regardless of stall or wb_valid; fwd_count SHALL hold.
REQ-023 A history entry SHALL match when its valid=1, its rd equals rs2_addr, and rd is not 0.
REQ-024 operand_b SHALL be combinational with zero latency, and SHALL be the first true of these, in order:
- alu_b_src=1: imm, fwd_src=FWD_IMM.
- H0 matches: H0.data, fwd_src=FWD_H0.
- H1 matches: H1.data, fwd_src=FWD_H1.
- otherwise: rs2_data, fwd_src=FWD_NONE.
REQ-025 If H0 and H1 both match, H0 SHALL win.
REQ-026 The current-cycle wb_* inputs SHALL NOT bypass into operand_b; the register file covers same-cycle writes.
REQ-027 fwd_count SHALL increment by 1 on each edge where stall=0, flush=0 and fwd_src is FWD_H0 or FWD_H1.
REQ-028 fwd_count SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-029 When rst_n=0 at a clock edge, both valid bits, both rd fields, both data fields and fwd_count SHALL clear to 0; reset overrides flush and stall.
REQ-030 After reset, with alu_b_src=0, operand_b SHALL equal rs2_data and fwd_src SHALL be FWD_NONE.
REQ-031 Reset asserted mid-sequence SHALL discard all history in the same edge, with no forwarding on the following cycle.

Structure
REQ-032 A shared package riscv_pkg SHALL hold:
- XLEN and REG_AW defaults.
- enum fwd_src_e {FWD_NONE=0, FWD_H0=1, FWD_H1=2, FWD_IMM=3}.
- struct hist_entry_t {valid, rd, data}.
REQ-033 One sub-module, fwd_hist_entry, SHALL implement one history register with load/clear/hold controls; it SHALL be instantiated twice.

Verification
REQ-034 Reset check: rst_n=0 for 2 cycles, then rs2_addr=3, rs2_data=32'h11 -> operand_b=32'h11, fwd_src=FWD_NONE, fwd_count=0.
REQ-035 Forwarding check:
- wb_valid=1, wb_rd=5, wb_data=32'hAAAA for 1 cycle; then rs2_addr=5, rs2_data=0 -> operand_b=32'hAAAA, FWD_H0.
- One idle cycle later -> FWD_H1, 32'hAAAA.
- One further idle cycle -> rs2_data, FWD_NONE.
REQ-036 Priority check: writes x7=1 then x7=2 on consecutive cycles, rs2_addr=7 -> operand_b=2, FWD_H0; set alu_b_src=1, imm=32'hFFFFFFFF -> operand_b=32'hFFFFFFFF, FWD_IMM.
REQ-037 x0 check: write wb_rd=0, wb_data=32'h55, then rs2_addr=0, rs2_data=0 -> operand_b=0, FWD_NONE.
REQ-038 Stall/flush check:
- H0 holds x4=9; stall=1 for 3 cycles with wb_valid=1, wb_rd=4, wb_data=8 -> operand_b stays 9 and fwd_count holds.
- Then flush=1 together with wb_valid=1 -> next cycle FWD_NONE.
REQ-039 Saturation check: force 65540 forwarding cycles -> fwd_count=16'hFFFF, with no wrap to 0.
